// File: rtl/adder_accum.sv
// Frame accumulator around an external 32-bit adder: sums N_WORDS words
// per frame and presents the total with a sticky unsigned-overflow flag.
module adder_accum #(
    parameter int N_WORDS = 8,
    parameter int CNT_W   = $clog2(N_WORDS + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic [31:0]      i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [31:0]      o_add_a,
    output logic [31:0]      o_add_b,
    input  logic [31:0]      i_add_s,
    output logic [31:0]      o_sum,
    output logic             o_ovf,
    output logic             o_sum_valid,
    input  logic             i_sum_ready
);

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);

    logic [31:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [0:0]       r_state;

    logic             w_accept;
    logic             w_last;
    logic             w_wrap;

    assign o_ready     = (r_state == ST_ACC);
    assign o_sum_valid = (r_state == ST_DONE);
    assign o_add_a     = r_acc;
    assign o_add_b     = i_data;
    assign o_sum       = r_acc;
    assign o_ovf       = r_ovf;

    assign w_accept = i_valid & o_ready;
    assign w_last   = (r_cnt == LAST_CNT);
    // No carry-out from the adder: a wrapped sum is smaller than the old total
    assign w_wrap   = (i_add_s < r_acc);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc   <= 32'd0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= ST_ACC;
        end else if (i_clear) begin
            r_acc   <= 32'd0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= ST_ACC;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        r_acc <= i_add_s;
                        r_ovf <= r_ovf | w_wrap;
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (i_sum_ready) begin
                        r_acc   <= 32'd0;
                        r_ovf   <= 1'b0;
                        r_state <= ST_ACC;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

endmodule
